// File: rtl/rv_pkg.sv
// RV32I decode vocabulary shared by the decode stage: opcodes, op classes, decoded packet and immediate builders.
package rv_pkg;

  localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
  localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_cls_e;

  typedef struct packed {
    op_cls_e     cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side push bus and dispatch-side issue packet of the decode stage.
// master = pipeline surroundings (fetch, dispatch, ROB control); slave = decode_stage.
interface decode_stage_if;
  logic        rdy_in;
  logic        clear;
  logic        from_if;
  logic [31:0] from_if_ins;
  logic [31:0] from_if_pc;
  logic        if_stall;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [3:0]  out_cls;
  logic [2:0]  out_f3;
  logic        out_f7b5;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;

  modport master (
    output rdy_in, clear, from_if, from_if_ins, from_if_pc, out_ready,
    input  if_stall, out_valid, out_pc, out_cls, out_f3, out_f7b5,
           out_rd, out_rs1, out_rs2, out_imm
  );

  modport slave (
    input  rdy_in, clear, from_if, from_if_ins, from_if_pc, out_ready,
    output if_stall, out_valid, out_pc, out_cls, out_f3, out_f7b5,
           out_rd, out_rs1, out_rs2, out_imm
  );
endinterface

// File: rtl/rv32i_decode_core.sv
// Combinational RV32I field decode: class, funct3, ins[30], register indices and class immediate.
// Zero latency; no state, so no backpressure of its own.
module rv32i_decode_core
  import rv_pkg::*;
(
  input  logic [31:0] ins_i,
  output decode_t     dec_o
);

  logic [6:0] opc;
  assign opc = ins_i[6:0];

  always_comb begin
    dec_o     = '0;
    dec_o.cls = CLS_ILLEGAL;
    case (opc)
      OPC_ALU_R: begin
        dec_o.cls = CLS_ALU_R;
        dec_o.rd  = ins_i[11:7];
        dec_o.rs1 = ins_i[19:15];
        dec_o.rs2 = ins_i[24:20];
      end
      OPC_ALU_I: begin
        dec_o.cls = CLS_ALU_I;
        dec_o.rd  = ins_i[11:7];
        dec_o.rs1 = ins_i[19:15];
        // SLLI/SRLI/SRAI carry a 5-bit shamt; ins[30] still selects SRA via f7b5
        if (ins_i[13:12] == 2'b01) begin
          dec_o.imm = {27'b0, ins_i[24:20]};
        end else begin
          dec_o.imm = imm_i(ins_i);
        end
      end
      OPC_LOAD: begin
        dec_o.cls = CLS_LOAD;
        dec_o.rd  = ins_i[11:7];
        dec_o.rs1 = ins_i[19:15];
        dec_o.imm = imm_i(ins_i);
      end
      OPC_STORE: begin
        dec_o.cls = CLS_STORE;
        dec_o.rs1 = ins_i[19:15];
        dec_o.rs2 = ins_i[24:20];
        dec_o.imm = imm_s(ins_i);
      end
      OPC_BRANCH: begin
        dec_o.cls = CLS_BRANCH;
        dec_o.rs1 = ins_i[19:15];
        dec_o.rs2 = ins_i[24:20];
        dec_o.imm = imm_b(ins_i);
      end
      OPC_JAL: begin
        dec_o.cls = CLS_JAL;
        dec_o.rd  = ins_i[11:7];
        dec_o.imm = imm_j(ins_i);
      end
      OPC_JALR: begin
        dec_o.cls = CLS_JALR;
        dec_o.rd  = ins_i[11:7];
        dec_o.rs1 = ins_i[19:15];
        dec_o.imm = imm_i(ins_i);
      end
      OPC_LUI: begin
        dec_o.cls = CLS_LUI;
        dec_o.rd  = ins_i[11:7];
        dec_o.imm = imm_u(ins_i);
      end
      OPC_AUIPC: begin
        dec_o.cls = CLS_AUIPC;
        dec_o.rd  = ins_i[11:7];
        dec_o.imm = imm_u(ins_i);
      end
      default: ;
    endcase
    if (dec_o.cls != CLS_ILLEGAL) begin
      dec_o.f3   = ins_i[14:12];
      dec_o.f7b5 = ins_i[30];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Fetch->dispatch decode: 2**DQ_WIDTH-entry queue feeding a registered issue packet; push-to-valid is 2 edges, 1/cycle.
// Packet holds while out_valid && !out_ready; if_stall asserts with <=1 free slot; pushes into a full queue are dropped.
module decode_stage
  import rv_pkg::*;
#(
  parameter int DQ_WIDTH = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  decode_stage_if.slave bus
);

  localparam int DQ_SIZE = 1 << DQ_WIDTH;
  localparam logic [DQ_WIDTH:0] CNT_MAX   = {1'b1, {DQ_WIDTH{1'b0}}};
  localparam logic [DQ_WIDTH:0] CNT_STALL = {1'b0, {DQ_WIDTH{1'b1}}};

  logic [31:0]         ins_mem_q [DQ_SIZE];
  logic [31:0]         pc_mem_q  [DQ_SIZE];
  logic [DQ_WIDTH-1:0] head_q, head_d;
  logic [DQ_WIDTH-1:0] tail_q, tail_d;
  logic [DQ_WIDTH:0]   count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_pc_q, out_pc_d;
  decode_t             out_q, out_d;
  decode_t             dec;
  logic                ovf_q, ovf_d;
  logic                full, empty, flush, push, pop;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);
  assign flush = bus.rdy_in && bus.clear;
  assign push  = bus.rdy_in && !bus.clear && bus.from_if && !full;
  assign pop   = bus.rdy_in && !bus.clear && (!out_valid_q || bus.out_ready) && !empty;

  rv32i_decode_core u_core (
    .ins_i (ins_mem_q[head_q]),
    .dec_o (dec)
  );

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (bus.rdy_in) begin
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      // Pop reads the pre-edge head, so a push into an empty queue waits one cycle
      if (pop) begin
        head_d      = head_q + 1'b1;
        out_valid_d = 1'b1;
        out_pc_d    = pc_mem_q[head_q];
        out_d       = dec;
      end else if (bus.out_ready && out_valid_q) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
      if (bus.from_if && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
    end
  end

  // Payload storage needs no reset: count_q gates every read
  always_ff @(posedge clk_in) begin
    if (push) begin
      ins_mem_q[tail_q] <= bus.from_if_ins;
      pc_mem_q[tail_q]  <= bus.from_if_pc;
    end
  end

  assign bus.if_stall  = (count_q >= CNT_STALL);
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_cls   = out_q.cls;
  assign bus.out_f3    = out_q.f3;
  assign bus.out_f7b5  = out_q.f7b5;
  assign bus.out_rd    = out_q.rd;
  assign bus.out_rs1   = out_q.rs1;
  assign bus.out_rs2   = out_q.rs2;
  assign bus.out_imm   = out_q.imm;

  a_count_bound: assert property (@(posedge clk_in) disable iff (rst_in) count_q <= CNT_MAX);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode classes, backpressure, flush, pointer wrap and global enable.
module tb_decode_stage;
  import rv_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  int   tests = 0;
  int   fails = 0;

  decode_stage_if bus();

  decode_stage #(.DQ_WIDTH(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    bus.from_if     = 1'b1;
    bus.from_if_ins = ins;
    bus.from_if_pc  = pc;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'b0010011};
  endfunction

  task automatic test_reset();
    rst_in = 1'b1; bus.rdy_in = 1'b1; bus.out_ready = 1'b0; bus.clear = 1'b0;
    bus.from_if = 1'b0; bus.from_if_ins = '0; bus.from_if_pc = '0;
    step(); step();
    tests++;
    if ({bus.out_valid, bus.if_stall} !== 2'b00) begin
      fails++; $display("FAIL reset_flags: got valid/stall %b, want 00", {bus.out_valid, bus.if_stall});
    end
    tests++;
    if ({bus.out_pc, bus.out_imm, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_f3, bus.out_f7b5} !== '0) begin
      fails++; $display("FAIL reset_fields: got pc %h imm %h cls %0d, want all zero", bus.out_pc, bus.out_imm, bus.out_cls);
    end
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(addi(5'(k + 1), 12'(k)), 32'h40 + 32'(4 * k));
      step();
    end
    bus.from_if = 1'b0;
    tests++;
    if ({bus.out_valid, bus.if_stall, dut.count_q} !== {2'b11, 3'd3}) begin
      fails++; $display("FAIL reset_prefill: got valid/stall/count %b, want 11011", {bus.out_valid, bus.if_stall, dut.count_q});
    end
    #2 rst_in = 1'b1;
    #1;
    tests++;
    if ({bus.out_valid, bus.if_stall, dut.count_q} !== 5'b0) begin
      fails++; $display("FAIL reset_async: got valid/stall/count %b, want 00000", {bus.out_valid, bus.if_stall, dut.count_q});
    end
    step();
    rst_in = 1'b0;
    step();
    tests++;
    if ({bus.out_valid, bus.if_stall, dut.count_q} !== 5'b0) begin
      fails++; $display("FAIL reset_after: got valid/stall/count %b, want 00000", {bus.out_valid, bus.if_stall, dut.count_q});
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    drive(32'h00500093, 32'h0);
    step();
    bus.from_if = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL single_idle: got valid %b, want 0", bus.out_valid);
    end
    step();
    tests++;
    if ({bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_imm, bus.out_pc} !==
        {1'b1, CLS_ALU_I, 5'd1, 5'd0, 32'd5, 32'd0}) begin
      fails++; $display("FAIL single_addi: got v%b cls %0d rd %0d rs1 %0d imm %h pc %h, want v1 cls 1 rd 1 rs1 0 imm 5 pc 0",
                        bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_imm, bus.out_pc);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL single_drain: got valid %b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(32'hFFC12283, 32'h10);
    step();
    drive(32'h00512423, 32'h14);
    step();
    tests++;
    if ({bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc} !==
        {1'b1, CLS_LOAD, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'h10}) begin
      fails++; $display("FAIL b2b_load: got cls %0d rd %0d rs1 %0d rs2 %0d imm %h pc %h, want 2/5/2/0/fffffffc/10",
                        bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
    end
    drive(32'h123451B7, 32'h18);
    step();
    tests++;
    if ({bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc} !==
        {1'b1, CLS_STORE, 5'd0, 5'd2, 5'd5, 32'd8, 32'h14}) begin
      fails++; $display("FAIL b2b_store: got cls %0d rd %0d rs1 %0d rs2 %0d imm %h pc %h, want 3/0/2/5/8/14",
                        bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
    end
    bus.from_if = 1'b0;
    step();
    tests++;
    if ({bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc} !==
        {1'b1, CLS_LUI, 5'd3, 5'd0, 5'd0, 32'h12345000, 32'h18}) begin
      fails++; $display("FAIL b2b_lui: got cls %0d rd %0d rs1 %0d rs2 %0d imm %h pc %h, want 7/3/0/0/12345000/18",
                        bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
    end
    step();
  endtask

  task automatic test_shift_branch();
    bus.out_ready = 1'b1;
    drive(32'h40515193, 32'h20);
    step();
    drive(32'h00209863, 32'h24);
    step();
    bus.from_if = 1'b0;
    tests++;
    if ({bus.out_cls, bus.out_f3, bus.out_f7b5, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm} !==
        {CLS_ALU_I, 3'd5, 1'b1, 5'd3, 5'd2, 5'd0, 32'd5}) begin
      fails++; $display("FAIL srai: got cls %0d f3 %0d f7b5 %b rd %0d rs1 %0d rs2 %0d imm %h, want 1/5/1/3/2/0/5",
                        bus.out_cls, bus.out_f3, bus.out_f7b5, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm);
    end
    step();
    tests++;
    if ({bus.out_cls, bus.out_f3, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm} !==
        {CLS_BRANCH, 3'd1, 5'd0, 5'd1, 5'd2, 32'd16}) begin
      fails++; $display("FAIL bne: got cls %0d f3 %0d rd %0d rs1 %0d rs2 %0d imm %h, want 4/1/0/1/2/10",
                        bus.out_cls, bus.out_f3, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm);
    end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(addi(5'd31, 12'h7FF), 32'h300);
    step();
    bus.from_if = 1'b0;
    step();
    tests++;
    if ({bus.out_valid, bus.out_pc, dut.ovf_q} !== {1'b1, 32'h300, 1'b0}) begin
      fails++; $display("FAIL bp_blocker: got valid %b pc %h ovf %b, want 1 300 0", bus.out_valid, bus.out_pc, dut.ovf_q);
    end
    for (int k = 1; k <= 6; k++) begin
      drive(addi(5'(k), 12'(k)), 32'h300 + 32'(4 * k));
      step();
      tests++;
      if (bus.if_stall !== (k >= 3)) begin
        fails++; $display("FAIL bp_stall_%0d: got %b, want %b", k, bus.if_stall, (k >= 3));
      end
      tests++;
      if ({bus.out_valid, bus.out_pc, bus.out_rd, bus.out_imm} !== {1'b1, 32'h300, 5'd31, 32'h7FF}) begin
        fails++; $display("FAIL bp_hold_%0d: got valid %b pc %h rd %0d imm %h, want 1 300 31 7ff",
                          k, bus.out_valid, bus.out_pc, bus.out_rd, bus.out_imm);
      end
    end
    bus.from_if = 1'b0;
    tests++;
    if (dut.ovf_q !== 1'b1) begin
      fails++; $display("FAIL bp_overflow_flag: got %b, want 1", dut.ovf_q);
    end
    bus.out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      tests++;
      if ({bus.out_valid, bus.out_pc, bus.out_rd} !== {1'b1, 32'h300 + 32'(4 * j), 5'(j)}) begin
        fails++; $display("FAIL bp_drain_%0d: got valid %b pc %h rd %0d, want 1 %h %0d",
                          j, bus.out_valid, bus.out_pc, bus.out_rd, 32'h300 + 32'(4 * j), j);
      end
    end
    step();
    tests++;
    if ({bus.out_valid, bus.if_stall} !== 2'b00) begin
      fails++; $display("FAIL bp_drained: got valid/stall %b, want 00", {bus.out_valid, bus.if_stall});
    end
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(addi(5'(k + 10), 12'(k)), 32'h600 + 32'(4 * k));
      step();
    end
    bus.from_if = 1'b0;
    tests++;
    if ({bus.out_valid, bus.if_stall, dut.count_q} !== {2'b11, 3'd4}) begin
      fails++; $display("FAIL clear_prefill: got valid/stall/count %b, want 11100", {bus.out_valid, bus.if_stall, dut.count_q});
    end
    bus.clear = 1'b1;
    drive(addi(5'd7, 12'd7), 32'h700);
    step();
    bus.clear = 1'b0;
    bus.from_if = 1'b0;
    tests++;
    if ({bus.out_valid, bus.if_stall, dut.count_q} !== 5'b0) begin
      fails++; $display("FAIL clear_flush: got valid/stall/count %b, want 00000", {bus.out_valid, bus.if_stall, dut.count_q});
    end
    bus.out_ready = 1'b1;
    step(); step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL clear_no_emit: got valid %b pc %h, want 0", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_illegal_jal_wrap();
    bus.out_ready = 1'b1;
    drive(32'h0000007F, 32'h200);
    step();
    drive(32'h008000EF, 32'h204);
    step();
    bus.from_if = 1'b0;
    tests++;
    if ({bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc} !==
        {1'b1, CLS_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0, 32'h200}) begin
      fails++; $display("FAIL illegal: got cls %0d rd %0d rs1 %0d rs2 %0d imm %h pc %h, want 9/0/0/0/0/200",
                        bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
    end
    step();
    tests++;
    if ({bus.out_valid, bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc} !==
        {1'b1, CLS_JAL, 5'd1, 5'd0, 5'd0, 32'd8, 32'h204}) begin
      fails++; $display("FAIL jal: got cls %0d rd %0d rs1 %0d rs2 %0d imm %h pc %h, want 5/1/0/0/8/204",
                        bus.out_cls, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
    end
    step();
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(addi(5'(k + 1), 12'(k + 100)), 32'h400 + 32'(4 * k));
      else bus.from_if = 1'b0;
      step();
      if (k >= 1) begin
        tests++;
        if ({bus.out_valid, bus.out_pc, bus.out_rd, bus.out_imm} !== {1'b1, 32'h400 + 32'(4 * (k - 1)), 5'(k), 32'(k + 99)}) begin
          fails++; $display("FAIL wrap_%0d: got valid %b pc %h rd %0d imm %0d, want 1 %h %0d %0d",
                            k - 1, bus.out_valid, bus.out_pc, bus.out_rd, bus.out_imm, 32'h400 + 32'(4 * (k - 1)), k, k + 99);
        end
      end
    end
    step();
    tests++;
    if ({bus.out_valid, dut.count_q} !== 4'b0) begin
      fails++; $display("FAIL wrap_end: got valid/count %b, want 0000", {bus.out_valid, dut.count_q});
    end
  endtask

  task automatic test_rdy_hold();
    bus.rdy_in = 1'b0;
    bus.out_ready = 1'b1;
    drive(addi(5'd9, 12'd9), 32'h500);
    step(); step();
    bus.from_if = 1'b0;
    tests++;
    if ({bus.out_valid, dut.count_q} !== 4'b0) begin
      fails++; $display("FAIL rdy_no_push: got valid/count %b, want 0000", {bus.out_valid, dut.count_q});
    end
    bus.rdy_in = 1'b1;
    bus.out_ready = 1'b0;
    drive(addi(5'd9, 12'd9), 32'h500);
    step();
    bus.from_if = 1'b0;
    step();
    bus.rdy_in = 1'b0;
    bus.out_ready = 1'b1;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    tests++;
    if ({bus.out_valid, bus.out_pc, bus.out_rd} !== {1'b1, 32'h500, 5'd9}) begin
      fails++; $display("FAIL rdy_hold: got valid %b pc %h rd %0d, want 1 500 9", bus.out_valid, bus.out_pc, bus.out_rd);
    end
    bus.rdy_in = 1'b1;
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL rdy_resume: got valid %b, want 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_shift_branch();
    test_backpressure();
    test_clear();
    test_illegal_jal_wrap();
    test_rdy_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
